fib_seq_engine: RTL and testbench

- Parametrised successor to the single-width Fibonacci core: computes term n of a generalised Fibonacci recurrence x(k) = x(k-1) + x(k-2).
- Seeds x(0) and x(1) are programmable, so Fibonacci, Lucas and other sequences use the same block.
- Optional modular mode (x mod M), overflow detection, input error reporting, abort, and a one-cycle done strobe.
- Sits behind a start/busy control interface, driven by the LED/UART demo top or a soft-CPU register wrapper.

---
 rtl/fib_seq_if.sv | 29 ++
 rtl/fib_seq_engine.sv | 90 +++++++++
 tb/tb_fib_seq_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fib_seq_if.sv
// Control/data bundle between a driver (demo top, CPU wrapper) and the
// generalised Fibonacci engine.
interface fib_seq_if #(
  parameter int WIDTH = 32,
  parameter int N_W   = 32
);
  logic             start;
  logic [N_W-1:0]   n;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic             mod_en;
  logic [WIDTH-1:0] modulus;
  logic             abort;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             err;

  modport master (
    output start, n, seed0, seed1, mod_en, modulus, abort,
    input  result, busy, done, overflow, err
  );

  modport slave (
    input  start, n, seed0, seed1, mod_en, modulus, abort,
    output result, busy, done, overflow, err
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Iterative generalised Fibonacci engine: x(k)=x(k-1)+x(k-2) with programmable
// seeds, optional mod-M arithmetic, overflow tracking and abort.
module fib_seq_engine #(
  parameter int WIDTH = 32,
  parameter int N_W   = 32
) (
  input  logic     clk,
  input  logic     rst,
  fib_seq_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b, m_r;
  logic [N_W-1:0]   cnt;
  logic             mod_r, ovf_a, ovf_b;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] sm, nxt;
  logic             carry, bad_req;

  // Operands stay below M in mod mode, so s-M fits in WIDTH bits.
  assign s       = {1'b0, a} + {1'b0, b};
  assign sm      = s[WIDTH-1:0] - m_r;
  assign nxt     = (mod_r && (s >= {1'b0, m_r})) ? sm : s[WIDTH-1:0];
  assign carry   = !mod_r && s[WIDTH];
  assign bad_req = bus.mod_en && ((bus.modulus == '0) ||
                   (bus.seed0 >= bus.modulus) || (bus.seed1 >= bus.modulus));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      m_r          <= '0;
      cnt          <= '0;
      mod_r        <= 1'b0;
      ovf_a        <= 1'b0;
      ovf_b        <= 1'b0;
      bus.result   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bad_req) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
            end else begin
              a        <= bus.seed0;
              b        <= bus.seed1;
              cnt      <= bus.n;
              mod_r    <= bus.mod_en;
              m_r      <= bus.modulus;
              ovf_a    <= 1'b0;
              ovf_b    <= 1'b0;
              bus.busy <= 1'b1;
              bus.err  <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (cnt == '0) begin
            // Only ovf_a reaches the result; the look-ahead term's carry is dropped.
            bus.result   <= a;
            bus.overflow <= ovf_a;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            a     <= b;
            ovf_a <= ovf_a | ovf_b;
            b     <= nxt;
            ovf_b <= ovf_b | carry;
            cnt   <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench for fib_seq_engine: vector table plus abort/reset/busy sequences.
module tb_fib_seq_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_seq_if #(.WIDTH(32), .N_W(32)) bus ();

  fib_seq_engine #(.WIDTH(32), .N_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] n;
    logic [31:0] s0;
    logic [31:0] s1;
    logic        me;
    logic [31:0] m;
    logic [31:0] res;
    logic        ovf;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vt [15];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive a request for one cycle; returns #1 after the sampling edge E0.
  task automatic launch(input logic [31:0] n, input logic [31:0] s0, input logic [31:0] s1,
                        input logic me, input logic [31:0] m, input logic ab);
    @(negedge clk);
    bus.start = 1'b1; bus.n = n; bus.seed0 = s0; bus.seed1 = s1;
    bus.mod_en = me; bus.modulus = m; bus.abort = ab;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  // Edges from now until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat >= 0) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 200) lat = -1;
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
  endtask

  initial begin
    int lat, seen;
    bus.start = 0; bus.n = 0; bus.seed0 = 0; bus.seed1 = 0;
    bus.mod_en = 0; bus.modulus = 0; bus.abort = 0;

    //        n      s0  s1  me  M      result       ovf er lat
    vt[0]  = '{32'd10, 0, 1, 1'b0, 0,    32'd55,         1'b0, 1'b0, 11};
    vt[1]  = '{32'd15, 0, 1, 1'b0, 0,    32'd610,        1'b0, 1'b0, 16};
    vt[2]  = '{32'd0,  0, 1, 1'b0, 0,    32'd0,          1'b0, 1'b0, 1};
    vt[3]  = '{32'd1,  0, 1, 1'b0, 0,    32'd1,          1'b0, 1'b0, 2};
    vt[4]  = '{32'd10, 2, 1, 1'b0, 0,    32'd123,        1'b0, 1'b0, 11};
    vt[5]  = '{32'd47, 0, 1, 1'b0, 0,    32'd2971215073, 1'b0, 1'b0, 48};
    vt[6]  = '{32'd48, 0, 1, 1'b0, 0,    32'd512559680,  1'b1, 1'b0, 49};
    vt[7]  = '{32'd3,  0, 1, 1'b1, 0,    32'd512559680,  1'b1, 1'b1, 0};
    vt[8]  = '{32'd5,  0, 1, 1'b0, 0,    32'd5,          1'b0, 1'b0, 6};
    vt[9]  = '{32'd10, 0, 1, 1'b1, 7,    32'd6,          1'b0, 1'b0, 11};
    vt[10] = '{32'd30, 0, 1, 1'b1, 1000, 32'd40,         1'b0, 1'b0, 31};
    vt[11] = '{32'd4,  0, 5, 1'b1, 5,    32'd40,         1'b0, 1'b1, 0};
    vt[12] = '{32'd2,  4, 4, 1'b1, 5,    32'd3,          1'b0, 1'b0, 3};
    vt[13] = '{32'd2,  3, 4, 1'b0, 0,    32'd7,          1'b0, 1'b0, 3};
    vt[14] = '{32'd1,  5, 0, 1'b1, 5,    32'd7,          1'b0, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset result",   bus.result,   0);
    chk("reset busy",     bus.busy,     0);
    chk("reset done",     bus.done,     0);
    chk("reset overflow", bus.overflow, 0);
    chk("reset err",      bus.err,      0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      launch(vt[i].n, vt[i].s0, vt[i].s1, vt[i].me, vt[i].m, 1'b0);
      chk($sformatf("v%0d busy", i), bus.busy, !vt[i].er);
      wait_done(lat);
      chk($sformatf("v%0d latency", i),  lat,          vt[i].lat);
      chk($sformatf("v%0d result", i),   bus.result,   vt[i].res);
      chk($sformatf("v%0d overflow", i), bus.overflow, vt[i].ovf);
      chk($sformatf("v%0d err", i),      bus.err,      vt[i].er);
      @(posedge clk); #1;
      chk($sformatf("v%0d done pulse", i), bus.done, 0);
    end

    // Abort mid-run: no done, result held, err cleared by the accepted start.
    launch(20, 0, 1, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    count_done(30, seen);
    chk("abort no done", seen, 0);
    chk("abort result", bus.result, 7);
    chk("abort err", bus.err, 0);

    // Abort landing on the completion cycle wins.
    launch(3, 0, 1, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    chk("abort prio busy", bus.busy, 0);
    count_done(10, seen);
    chk("abort prio no done", seen, 0);
    chk("abort prio result", bus.result, 7);

    // Start while busy is ignored.
    launch(10, 0, 1, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.n = 3; bus.seed0 = 5; bus.seed1 = 5;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_done(lat);
    chk("busy start latency", lat, 8);
    chk("busy start result", bus.result, 55);

    // Abort in IDLE alongside start still launches.
    launch(2, 0, 1, 1'b0, 0, 1'b1);
    chk("idle abort busy", bus.busy, 1);
    wait_done(lat);
    chk("idle abort latency", lat, 3);
    chk("idle abort result", bus.result, 1);

    // Asynchronous reset mid-run.
    launch(15, 0, 1, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("midrst result", bus.result, 0);
    chk("midrst busy",   bus.busy,   0);
    chk("midrst done",   bus.done,   0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    count_done(20, seen);
    chk("midrst no done", seen, 0);
    launch(15, 0, 1, 1'b0, 0, 1'b0);
    wait_done(lat);
    chk("midrst rerun latency", lat, 16);
    chk("midrst rerun result", bus.result, 610);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
